// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared L2 access controller types and default parameters
// Contents: controller state enum, default geometry/latency constants.
package cache_pkg;

    localparam int L2_ADDR_W     = 32;
    localparam int L2_BLOCKSIZE2 = 16;
    localparam int L2_LINES2     = 256;
    localparam int L2_MEM_LAT    = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } l2_state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter
// Ports: req[1:0] requests (bit0 instruction, bit1 data), last index of the
// side served last, grant[1:0] one-hot grant (all zero when no request).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie the side that was not served last wins.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/l2_access_ctrl.sv
// rtl/l2_access_ctrl.sv - L2 tag lookup/fill controller shared by L1 I and D misses
// Ports: clk, rst (async active-low); i_req/i_addr, d_req/d_addr miss requests;
// flush invalidates all lines when idle; i_done/d_done one-cycle completion
// pulses with l2_hit; busy when not idle; hit_cnt/miss_cnt saturating counters.
module l2_access_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = L2_ADDR_W,
    parameter int BLOCKSIZE2 = L2_BLOCKSIZE2,
    parameter int LINES2     = L2_LINES2,
    parameter int MEM_LAT    = L2_MEM_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              flush,
    output logic              i_done,
    output logic              d_done,
    output logic              l2_hit,
    output logic              busy,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFF_W = $clog2(BLOCKSIZE2);
    localparam int IDX_W = $clog2(LINES2);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    l2_state_t         state, state_nxt;
    logic [LINES2-1:0] valid;
    logic [TAG_W-1:0]  tag_mem [LINES2];
    logic [IDX_W-1:0]  idx_r;
    logic [TAG_W-1:0]  tag_r;
    logic              owner;      // 0 = instruction, 1 = data
    logic              last_d;     // side served last, 1 = data
    logic              hit_r;
    logic [CNT_W-1:0]  fill_cnt;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] addr_sel;
    logic              lookup_hit;
    logic              fill_done;
    logic              unused_offset;

    rr_arb2 u_arb (
        .req   ({d_req, i_req}),
        .last  (last_d),
        .grant (grant)
    );

    assign addr_sel      = grant[1] ? d_addr : i_addr;
    assign unused_offset = ^addr_sel[OFF_W-1:0];
    assign lookup_hit    = valid[idx_r] && (tag_mem[idx_r] == tag_r);
    assign fill_done     = (fill_cnt == '0);

    assign busy   = (state != IDLE);
    assign i_done = (state == RESP) && !owner;
    assign d_done = (state == RESP) && owner;
    assign l2_hit = (state == RESP) && hit_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!flush && (grant != 2'b00)) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = lookup_hit ? RESP : FILL;
            FILL:    if (fill_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid    <= '0;
            idx_r    <= '0;
            tag_r    <= '0;
            owner    <= 1'b0;
            last_d   <= 1'b1;
            hit_r    <= 1'b0;
            fill_cnt <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (grant != 2'b00) begin
                        owner <= grant[1];
                        idx_r <= addr_sel[OFF_W +: IDX_W];
                        tag_r <= addr_sel[ADDR_W-1 -: TAG_W];
                    end
                end
                LOOKUP: begin
                    hit_r <= lookup_hit;
                    if (!lookup_hit) begin
                        fill_cnt <= CNT_W'(MEM_LAT - 1);
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        valid[idx_r] <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    last_d <= owner;
                    if (hit_r) begin
                        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
                    end else begin
                        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag array carries no reset; the valid vector alone qualifies it.
    always_ff @(posedge clk) begin
        if ((state == FILL) && fill_done) begin
            tag_mem[idx_r] <= tag_r;
        end
    end

endmodule

// File: tb/tb_l2_access_ctrl.sv
// tb/tb_l2_access_ctrl.sv - self-checking bench for l2_access_ctrl
module tb_l2_access_ctrl;

    localparam int MEM_LAT = 8;
    localparam int OFF_B   = 4;
    localparam int IDX_B   = 8;
    localparam int NLINES  = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        flush = 1'b0;
    logic        i_done, d_done, l2_hit, busy;
    logic [15:0] hit_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    l2_access_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .flush    (flush),
        .i_done   (i_done),
        .d_done   (d_done),
        .l2_hit   (l2_hit),
        .busy     (busy),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference model: 0 idle, 1 in flight, 2 completing.
    int          m_st = 0;
    int          m_wait = 0;
    bit          m_side = 0;
    bit          m_hit = 0;
    bit          m_last = 1;
    int          m_hits = 0;
    int          m_misses = 0;
    logic [31:0] m_addr = '0;
    bit          m_valid [NLINES];
    logic [31:0] m_tag [NLINES];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> OFF_B) % NLINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (OFF_B + IDX_B);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = 0;
            m_wait = 0;
            m_last = 1;
            m_hits = 0;
            m_misses = 0;
            for (int k = 0; k < NLINES; k++) m_valid[k] = 0;
        end else begin
            case (m_st)
                0: begin
                    if (flush) begin
                        for (int k = 0; k < NLINES; k++) m_valid[k] = 0;
                    end else if (i_req || d_req) begin
                        m_side = (i_req && d_req) ? !m_last : d_req;
                        m_addr = m_side ? d_addr : i_addr;
                        m_hit  = m_valid[idx_of(m_addr)] && (m_tag[idx_of(m_addr)] == tag_of(m_addr));
                        m_wait = m_hit ? 1 : 1 + MEM_LAT;
                        m_st   = 1;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) m_st = 2;
                end
                default: begin
                    if (m_hit) begin
                        if (m_hits < 16'hFFFF) m_hits++;
                    end else begin
                        if (m_misses < 16'hFFFF) m_misses++;
                        m_valid[idx_of(m_addr)] = 1;
                        m_tag[idx_of(m_addr)]   = tag_of(m_addr);
                    end
                    m_last = m_side;
                    m_st   = 0;
                end
            endcase
        end
    end

    bit done_q [$];

    always @(negedge clk) begin
        chk("busy", busy, (m_st != 0));
        chk("i_done", i_done, (m_st == 2) && !m_side);
        chk("d_done", d_done, (m_st == 2) && m_side);
        chk("l2_hit", l2_hit, (m_st == 2) && m_hit);
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
        chk("one_done", i_done && d_done, 1'b0);
        if (i_done) done_q.push_back(1'b0);
        if (d_done) done_q.push_back(1'b1);
    end

    // All tasks start and end at posedge+#1.
    task automatic do_reset();
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
    endtask

    task automatic access(input bit side, input logic [31:0] addr, output int lat, output bit hit);
        int t0;
        bit got;
        if (side) begin d_addr = addr; d_req = 1'b1; end
        else      begin i_addr = addr; i_req = 1'b1; end
        t0 = cyc; got = 0; lat = -1; hit = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (side ? d_done : i_done) begin
                got = 1; lat = cyc - t0; hit = l2_hit;
            end
        end
        if (!got) chk("access_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (side) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic requester(input bit side, input int n, input bit randomize_it);
        logic [31:0] a;
        logic [31:0] tags [3];
        bit got, dropped;
        int gap;
        tags[0] = 32'h1; tags[1] = 32'h11; tags[2] = 32'h2;
        for (int t = 0; t < n; t++) begin
            if (randomize_it)
                a = (tags[$urandom_range(0, 2)] << 12) | ((32'h23 + $urandom_range(0, 2)) << 4) | $urandom_range(0, 15);
            else
                a = 32'h0000_1230;
            if (side) begin d_addr = a; d_req = 1'b1; end
            else      begin i_addr = a; i_req = 1'b1; end
            got = 0; dropped = 0;
            for (int k = 0; k < 300 && !got; k++) begin
                @(negedge clk);
                if (side ? d_done : i_done) got = 1;
                else if (randomize_it && !dropped && k >= 2 && m_st == 1 && m_side == side
                         && $urandom_range(0, 3) == 0) begin
                    dropped = 1;
                    if (side) d_req = 1'b0; else i_req = 1'b0;
                end
            end
            if (!got) chk("requester_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            gap = randomize_it ? $urandom_range(0, 2) : 0;
            if (gap > 0) begin
                if (side) d_req = 1'b0; else i_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        if (side) d_req = 1'b0; else i_req = 1'b0;
    endtask

    int lat;
    bit hit;
    bit stop_flush;
    bit exp_order [4];

    initial begin
        @(posedge clk); #1;
        do_reset();
        chk("reset_busy", busy, 1'b0);
        chk("reset_hit_cnt", hit_cnt, 16'd0);
        chk("reset_miss_cnt", miss_cnt, 16'd0);

        // Cold miss, repeat hit, conflict eviction.
        access(0, 32'h0000_1230, lat, hit);
        chk("cold_lat", lat, 32'd10);
        chk("cold_hit", hit, 1'b0);
        chk("cold_miss_cnt", miss_cnt, 16'd1);
        access(0, 32'h0000_1230, lat, hit);
        chk("repeat_lat", lat, 32'd2);
        chk("repeat_hit", hit, 1'b1);
        chk("repeat_hit_cnt", hit_cnt, 16'd1);
        access(1, 32'h0001_1230, lat, hit);
        chk("conflict_lat", lat, 32'd10);
        chk("conflict_hit", hit, 1'b0);
        access(0, 32'h0000_1230, lat, hit);
        chk("evicted_lat", lat, 32'd10);
        chk("evicted_hit", hit, 1'b0);
        chk("evicted_miss_cnt", miss_cnt, 16'd3);

        // Flush during FILL is ignored; flush in IDLE invalidates.
        access(1, 32'h0000_2240, lat, hit);
        fork
            access(0, 32'h0000_3350, lat, hit);
            begin
                repeat (4) begin @(posedge clk); #1; end
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
            end
        join
        access(1, 32'h0000_2240, lat, hit);
        chk("flush_in_fill_hit", hit, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        access(0, 32'h0000_1230, lat, hit);
        chk("after_flush_lat", lat, 32'd10);
        chk("after_flush_hit", hit, 1'b0);

        // Requester drops req after grant; done still arrives.
        access(0, 32'h0000_1230, lat, hit);
        i_addr = 32'h0000_4460; i_req = 1'b1;
        begin
            int t0;
            bit got;
            t0 = cyc; got = 0;
            repeat (3) begin @(posedge clk); #1; end
            i_req = 1'b0;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk);
                if (i_done) begin got = 1; lat = cyc - t0; end
            end
            chk("drop_done_seen", got, 1'b1);
            chk("drop_lat", lat, 32'd10);
            @(posedge clk); #1;
        end

        // Reset during FILL.
        i_addr = 32'h0000_5570; i_req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0; i_req = 1'b0;
        #1;
        chk("rst_fill_busy", busy, 1'b0);
        chk("rst_fill_done", i_done, 1'b0);
        chk("rst_fill_hit_cnt", hit_cnt, 16'd0);
        chk("rst_fill_miss_cnt", miss_cnt, 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        access(0, 32'h0000_1230, lat, hit);
        chk("post_rst_lat", lat, 32'd10);
        chk("post_rst_hit", hit, 1'b0);

        // Simultaneous requests alternate I, D, I, D from reset.
        do_reset();
        done_q.delete();
        fork
            requester(0, 2, 0);
            requester(1, 2, 0);
        join
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
        chk("tie_count", done_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < done_q.size(); k++) chk("tie_order", done_q[k], exp_order[k]);

        // Randomized traffic with random flush pulses.
        stop_flush = 0;
        fork
            begin
                fork
                    requester(0, 30, 1);
                    requester(1, 30, 1);
                join
                stop_flush = 1;
            end
            begin
                while (!stop_flush) begin
                    @(posedge clk); #1;
                    flush = ($urandom_range(0, 15) == 0);
                end
                flush = 1'b0;
            end
        join
        repeat (3) begin @(posedge clk); #1; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
